// File: rtl/control_unit_if.sv
// ============================================================================
// Module : control_unit_if
// Brief  : Control-unit bus between the sequencer and the 8-bit datapath/memory
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_unit_if;
  logic [7:0] instr;
  logic       zero_flag;
  logic       carry_flag;
  logic       mem_ready;
  logic       mem_rd;
  logic       mem_wr;
  logic       mar_sel;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       a_load;
  logic       b_load;
  logic [2:0] alu_op;
  logic       halted;
  logic [3:0] debug_State;
  logic [7:0] retired;

  modport master (
    input  instr, zero_flag, carry_flag, mem_ready,
    output mem_rd, mem_wr, mar_sel, ir_load, pc_inc, pc_load,
           a_load, b_load, alu_op, halted, debug_State, retired
  );

  modport slave (
    output instr, zero_flag, carry_flag, mem_ready,
    input  mem_rd, mem_wr, mar_sel, ir_load, pc_inc, pc_load,
           a_load, b_load, alu_op, halted, debug_State, retired
  );
endinterface

`default_nettype wire

// File: rtl/control_unit_fsm.sv
// ============================================================================
// Module : control_unit_fsm
// Brief  : Multi-cycle fetch/decode/execute sequencer with bounded memory wait
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit_fsm #(
  parameter int WAIT_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_HALT   = 4'd14,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] retired;
  logic [3:0] opcode;
  logic       wait_expired;

  assign opcode       = bus.instr[7:4];
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      retired  <= 8'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= 8'd0;
          end else if (wait_expired) begin
            state    <= S_FAULT;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt <= 8'd0;
          case (opcode)
            4'h0: begin
              state   <= S_FETCH;
              retired <= retired + 8'd1;
            end
            4'h1, 4'h2, 4'h7:
              state <= S_MEM;
            4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA:
              state <= S_EXEC;
            4'hF: begin
              state   <= S_HALT;
              retired <= retired + 8'd1;
            end
            default:
              state <= S_FAULT;
          endcase
        end
        S_EXEC: begin
          state    <= S_FETCH;
          wait_cnt <= 8'd0;
          retired  <= retired + 8'd1;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
            retired  <= retired + 8'd1;
          end else if (wait_expired) begin
            state    <= S_FAULT;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_HALT, S_FAULT: begin
          state    <= state;
          wait_cnt <= 8'd0;
        end
        default: begin
          state    <= S_FAULT;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Strobes are gated by rst so an in-flight access is dropped the moment reset rises.
  always_comb begin
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.mar_sel = 1'b0;
    bus.ir_load = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_load = 1'b0;
    bus.a_load  = 1'b0;
    bus.b_load  = 1'b0;
    bus.alu_op  = 3'd0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_rd  = 1'b1;
          bus.ir_load = bus.mem_ready;
          bus.pc_inc  = bus.mem_ready;
        end
        S_EXEC: begin
          case (opcode)
            4'h3, 4'h4, 4'h5, 4'h6: begin
              bus.alu_op = opcode[2:0] - 3'd3;
              bus.a_load = 1'b1;
            end
            4'h8:    bus.pc_load = 1'b1;
            4'h9:    bus.pc_load = bus.zero_flag;
            4'hA:    bus.pc_load = bus.carry_flag;
            default: bus.pc_load = 1'b0;
          endcase
        end
        S_MEM: begin
          bus.mar_sel = 1'b1;
          bus.mem_rd  = (opcode == 4'h1) || (opcode == 4'h2);
          bus.mem_wr  = (opcode == 4'h7);
          bus.a_load  = bus.mem_ready && (opcode == 4'h1);
          bus.b_load  = bus.mem_ready && (opcode == 4'h2);
        end
        default: ;
      endcase
    end
  end

  assign bus.halted      = !rst && ((state == S_HALT) || (state == S_FAULT));
  assign bus.debug_State = state;
  assign bus.retired     = retired;

endmodule

`default_nettype wire
